// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, memory-wait stalls with
// timeout, and branch flushes. Memory wait has priority over branch, which
// has priority over load-use. A branch that arrives while a memory wait is
// starting or in progress is remembered and flushed when the wait ends.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT  = 15,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] id_rs1,
  input  logic [2:0] id_rs2,
  input  logic       exe_mem_read,
  input  logic [2:0] exe_fwd_reg,
  input  logic       mem_mem_read,
  input  logic       mem_mem_write,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       id_exe_flush,
  output logic       if_id_flush,
  output logic       exe_mem_stall,
  output logic       mem_wb_bubble,
  output logic       mem_timeout,
  output logic [1:0] ctrl_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);
  localparam logic [2:0] FLUSH_VAL   = 3'(FLUSH_CYCLES);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic [2:0] flush_cnt, flush_nxt;
  logic       branch_pending, pend_nxt;
  logic       timeout_nxt;
  logic       mem_wait_req;
  logic       load_use;

  assign mem_wait_req = (mem_mem_read | mem_mem_write) & ~mem_ready;
  assign load_use     = exe_mem_read && (exe_fwd_reg != 3'd0) &&
                        ((exe_fwd_reg == id_rs1) || (exe_fwd_reg == id_rs2));
  assign ctrl_state   = state;

  // State, counters, pending-branch and sticky timeout registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      flush_cnt      <= '0;
      branch_pending <= 1'b0;
      mem_timeout    <= 1'b0;
    end else begin
      state          <= state_nxt;
      wait_cnt       <= wait_nxt;
      flush_cnt      <= flush_nxt;
      branch_pending <= pend_nxt;
      mem_timeout    <= timeout_nxt;
    end
  end

  // Next-state logic and combinational stall/flush outputs
  always_comb begin
    state_nxt     = state;
    wait_nxt      = wait_cnt;
    flush_nxt     = flush_cnt;
    pend_nxt      = branch_pending;
    timeout_nxt   = mem_timeout;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_exe_flush  = 1'b0;
    if_id_flush   = 1'b0;
    exe_mem_stall = 1'b0;
    mem_wb_bubble = 1'b0;
    case (state)
      IDLE: begin
        if (mem_wait_req) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = 8'd1;
          if (branch_taken) pend_nxt = 1'b1;
        end else if (branch_taken) begin
          state_nxt = FLUSH;
          flush_nxt = FLUSH_VAL;
        end else if (load_use) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_exe_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        pc_stall      = 1'b1;
        if_id_stall   = 1'b1;
        exe_mem_stall = 1'b1;
        mem_wb_bubble = 1'b1;
        if (branch_taken) pend_nxt = 1'b1;
        if (mem_ready || (wait_cnt == TIMEOUT_VAL)) begin
          wait_nxt = '0;
          if (!mem_ready) timeout_nxt = 1'b1;
          // A branch seen on the exit cycle itself is treated as pending too.
          if (branch_pending || branch_taken) begin
            state_nxt = FLUSH;
            flush_nxt = FLUSH_VAL;
            pend_nxt  = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      FLUSH: begin
        if_id_flush  = 1'b1;
        id_exe_flush = 1'b1;
        if (branch_taken) begin
          flush_nxt = FLUSH_VAL;
        end else if (flush_cnt <= 3'd1) begin
          state_nxt = IDLE;
          flush_nxt = '0;
        end else begin
          flush_nxt = flush_cnt - 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios followed by randomized
// traffic, all checked every cycle against a behavioural reference model.
module tb_pipeline_hazard_ctrl;

  localparam int TO = 15;
  localparam int FC = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] id_rs1, id_rs2, exe_fwd_reg;
  logic       exe_mem_read, mem_mem_read, mem_mem_write, mem_ready, branch_taken;
  logic       pc_stall, if_id_stall, id_exe_flush, if_id_flush;
  logic       exe_mem_stall, mem_wb_bubble, mem_timeout;
  logic [1:0] ctrl_state;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: mode 0 idle, 1 waiting on memory, 2 flushing
  int m_mode, m_wait, m_flush, m_pend, m_to;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .FLUSH_CYCLES(FC)) dut (
    .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .exe_mem_read(exe_mem_read), .exe_fwd_reg(exe_fwd_reg),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_ready(mem_ready), .branch_taken(branch_taken),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_exe_flush(id_exe_flush),
    .if_id_flush(if_id_flush), .exe_mem_stall(exe_mem_stall),
    .mem_wb_bubble(mem_wb_bubble), .mem_timeout(mem_timeout), .ctrl_state(ctrl_state)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_mode = 0; m_wait = 0; m_flush = 0; m_pend = 0; m_to = 0;
  endtask

  task automatic inputs_low();
    id_rs1 = '0; id_rs2 = '0; exe_fwd_reg = '0; exe_mem_read = 0;
    mem_mem_read = 0; mem_mem_write = 0; mem_ready = 0; branch_taken = 0;
  endtask

  // Expected outputs derived from the model mode and current inputs
  task automatic check_all();
    bit mem_op, hazard;
    int e_stall, e_idflush, e_ifflush, e_memstall;
    mem_op = (mem_mem_read || mem_mem_write);
    hazard = exe_mem_read && exe_fwd_reg != 0 &&
             (exe_fwd_reg == id_rs1 || exe_fwd_reg == id_rs2);
    e_stall = 0; e_idflush = 0; e_ifflush = 0; e_memstall = 0;
    if (m_mode == 0 && !(mem_op && !mem_ready) && !branch_taken && hazard) begin
      e_stall = 1; e_idflush = 1;
    end else if (m_mode == 1) begin
      e_stall = 1; e_memstall = 1;
    end else if (m_mode == 2) begin
      e_idflush = 1; e_ifflush = 1;
    end
    chk("ctrl_state",    8'(ctrl_state),    8'(m_mode));
    chk("pc_stall",      8'(pc_stall),      8'(e_stall));
    chk("if_id_stall",   8'(if_id_stall),   8'(e_stall));
    chk("id_exe_flush",  8'(id_exe_flush),  8'(e_idflush));
    chk("if_id_flush",   8'(if_id_flush),   8'(e_ifflush));
    chk("exe_mem_stall", 8'(exe_mem_stall), 8'(e_memstall));
    chk("mem_wb_bubble", 8'(mem_wb_bubble), 8'(e_memstall));
    chk("mem_timeout",   8'(mem_timeout),   8'(m_to));
  endtask

  // Advance the model across one rising edge using the inputs held over it
  task automatic model_step();
    bit mem_op;
    int pend;
    mem_op = (mem_mem_read || mem_mem_write);
    if (reset) begin
      model_clear();
      return;
    end
    case (m_mode)
      0: if (mem_op && !mem_ready) begin
           m_mode = 1; m_wait = 1; m_pend = int'(branch_taken);
         end else if (branch_taken) begin
           m_mode = 2; m_flush = FC;
         end
      1: begin
           pend = (m_pend != 0 || branch_taken) ? 1 : 0;
           if (mem_ready || m_wait == TO) begin
             if (!mem_ready) m_to = 1;
             m_wait = 0;
             m_pend = 0;
             if (pend != 0) begin m_mode = 2; m_flush = FC; end
             else m_mode = 0;
           end else begin
             m_wait = m_wait + 1;
             m_pend = pend;
           end
         end
      default: if (branch_taken) m_flush = FC;
               else if (m_flush <= 1) begin m_mode = 0; m_flush = 0; end
               else m_flush = m_flush - 1;
    endcase
  endtask

  // One clock cycle: inputs already driven after the falling edge
  task automatic cycle();
    #1;
    if (reset) model_clear();
    check_all();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  initial begin
    int cnt;
    inputs_low();
    model_clear();
    reset = 1;
    @(negedge clock);
    #1;
    chk("rst_state", 8'(ctrl_state), 8'd0);
    chk("rst_pc_stall", 8'(pc_stall), 8'd0);
    chk("rst_timeout", 8'(mem_timeout), 8'd0);
    cycle();
    cycle();
    reset = 0;
    cycle();

    // Load-use on rs2 for exactly one cycle
    exe_mem_read = 1; exe_fwd_reg = 3; id_rs2 = 3; id_rs1 = 5;
    #1;
    chk("lu_pc_stall", 8'(pc_stall), 8'd1);
    chk("lu_id_exe_flush", 8'(id_exe_flush), 8'd1);
    cycle();
    inputs_low();
    #1;
    chk("lu_release", 8'(pc_stall), 8'd0);
    chk("lu_state", 8'(ctrl_state), 8'd0);
    cycle();
    // Register zero never creates a hazard
    exe_mem_read = 1; exe_fwd_reg = 0; id_rs1 = 0;
    cycle();
    inputs_low();

    // Memory read, ready low for 4 cycles then high
    mem_mem_read = 1; cnt = 0;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i == 4);
      #1;
      if (ctrl_state == 2'd1) cnt++;
      if (ctrl_state == 2'd1) chk("mw_exe_mem_stall", 8'(exe_mem_stall), 8'd1);
      cycle();
    end
    chk("mw_cycles", 8'(cnt), 8'd4);
    inputs_low();
    #1;
    chk("mw_back_idle", 8'(ctrl_state), 8'd0);
    cycle();

    // Memory write never ready: timeout after 15 wait cycles
    mem_mem_write = 1; cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (ctrl_state == 2'd1) cnt++;
      else break;
    end
    chk("to_wait_cycles", 8'(cnt), 8'(TO));
    chk("to_flag", 8'(mem_timeout), 8'd1);
    inputs_low();
    for (int i = 0; i < 3; i++) cycle();
    chk("to_sticky", 8'(mem_timeout), 8'd1);
    reset = 1;
    cycle();
    reset = 0;
    chk("to_cleared", 8'(mem_timeout), 8'd0);

    // Branch pulse in IDLE: two flush cycles
    branch_taken = 1;
    cycle();
    branch_taken = 0; cnt = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (if_id_flush === 1'b1 && ctrl_state == 2'd2) cnt++;
      else break;
      cycle();
    end
    chk("br_flush_cycles", 8'(cnt), 8'(FC));
    chk("br_back_idle", 8'(ctrl_state), 8'd0);
    cycle();

    // Branch during MEM_WAIT goes straight to FLUSH on ready
    mem_mem_read = 1; mem_ready = 0;
    cycle();
    cycle();
    branch_taken = 1;
    cycle();
    branch_taken = 0;
    cycle();
    mem_ready = 1;
    cycle();
    inputs_low();
    #1;
    chk("bp_flush_entry", 8'(ctrl_state), 8'd2);
    cycle();
    cycle();
    chk("bp_idle", 8'(ctrl_state), 8'd0);
    // Pending bit must be gone: a plain wait now exits to IDLE
    mem_mem_read = 1;
    cycle();
    mem_ready = 1;
    cycle();
    inputs_low();
    chk("bp_cleared", 8'(ctrl_state), 8'd0);
    cycle();

    // Asynchronous reset between edges while in MEM_WAIT
    mem_mem_read = 1;
    cycle();
    cycle();
    #2;
    reset = 1;
    #1;
    chk("ar_state", 8'(ctrl_state), 8'd0);
    chk("ar_pc_stall", 8'(pc_stall), 8'd0);
    chk("ar_exe_mem_stall", 8'(exe_mem_stall), 8'd0);
    chk("ar_bubble", 8'(mem_wb_bubble), 8'd0);
    model_clear();
    inputs_low();
    cycle();
    reset = 0;
    cycle();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      id_rs1        = 3'($urandom_range(0, 7));
      id_rs2        = 3'($urandom_range(0, 7));
      exe_fwd_reg   = 3'($urandom_range(0, 7));
      exe_mem_read  = ($urandom_range(0, 1) == 1);
      mem_mem_read  = ($urandom_range(0, 9) < 2);
      mem_mem_write = ($urandom_range(0, 9) < 1);
      mem_ready     = ($urandom_range(0, 9) < ((i % 300 < 40) ? 0 : 4));
      branch_taken  = ($urandom_range(0, 9) < 1);
      reset         = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 0;
    inputs_low();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum MEM_WAIT cycles before abort (range 1..255).
REQ-002 Parameter FLUSH_CYCLES, default 2: cycles spent in FLUSH per taken branch (range 1..7).
REQ-003 clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately, independent of clock.
REQ-005 id_rs1, id_rs2  in  3 each  source register numbers of the instruction in ID.
REQ-006 exe_mem_read  in  1  instruction in EXE is a load.
REQ-007 exe_fwd_reg  in  3  destination register of the instruction in EXE.
REQ-008 mem_mem_read, mem_mem_write  in  1 each  instruction in MEM accesses data memory.
REQ-009 mem_ready  in  1  data memory completes the current access this cycle.
REQ-010 branch_taken  in  1  branch resolved taken in EXE this cycle.
REQ-011 pc_stall, if_id_stall  out  1 each  hold PC and IF/ID register.
REQ-012 id_exe_flush, if_id_flush  out  1 each  load bubble into ID/EXE and IF/ID, respectively.
REQ-013 exe_mem_stall  out  1  hold the EXE/MEM pipeline buffer.
REQ-014 mem_wb_bubble  out  1  MEM/WB register captures a bubble (regwrite=0).
REQ-015 mem_timeout  out  1  sticky error flag.
REQ-016 ctrl_state  out  2  current state: 0 IDLE, 1 MEM_WAIT, 2 FLUSH.

Function
REQ-017 FSM states IDLE, MEM_WAIT, FLUSH; state, wait counter (8 bits), flush counter (3 bits), branch_pending and mem_timeout are registers; all other outputs are combinational from state and inputs.
REQ-018 Load-use hazard = IDLE and exe_mem_read and exe_fwd_reg != 0 and (exe_fwd_reg == id_rs1 or exe_fwd_reg == id_rs2); asserts pc_stall, if_id_stall and id_exe_flush in that same cycle; no state change.
REQ-019 IDLE -> MEM_WAIT when (mem_mem_read or mem_mem_write) and mem_ready = 0; wait counter loads 1.
REQ-020 Memory op with mem_ready = 1 in IDLE completes with zero stall; FSM remains in IDLE.
REQ-021 In MEM_WAIT, pc_stall, if_id_stall, exe_mem_stall and mem_wb_bubble are all 1; id_exe_flush = 0.
REQ-022 MEM_WAIT -> IDLE on the cycle mem_ready = 1; stalls drop in the following cycle; wait counter clears.
REQ-023 MEM_WAIT with mem_ready = 0 and wait counter == MEM_TIMEOUT -> IDLE; mem_timeout set to 1 and held until reset.
REQ-024 IDLE with branch_taken = 1 and no memory wait condition -> FLUSH; flush counter loads FLUSH_CYCLES.
REQ-025 In FLUSH, if_id_flush = id_exe_flush = 1; flush counter decrements each cycle; FLUSH -> IDLE when counter reaches 1.
REQ-026 Priority: memory wait > branch > load-use; branch_taken together with a REQ-019 condition, or during MEM_WAIT, sets branch_pending.
REQ-027 On the MEM_WAIT -> IDLE exit with branch_pending = 1, the FSM enters FLUSH instead and clears branch_pending.
REQ-028 branch_taken in FLUSH reloads the flush counter to FLUSH_CYCLES (flush extended).
REQ-029 Load-use detection is suppressed in MEM_WAIT and FLUSH.

Reset
REQ-030 During or after reset: ctrl_state = 0, counters = 0, branch_pending = 0, mem_timeout = 0.
REQ-031 With inputs low, every stall, flush and bubble output reads 0 while in reset.
REQ-032 Reset asserted mid-MEM_WAIT or mid-FLUSH returns the FSM to IDLE asynchronously, with no residual stall.

Verification
REQ-033 exe_mem_read=1, exe_fwd_reg=3, id_rs2=3 -> pc_stall=if_id_stall=id_exe_flush=1 for exactly that cycle; ctrl_state stays 0.
REQ-034 mem_mem_read=1, mem_ready low 4 cycles then high -> ctrl_state=1 for 4 cycles, exe_mem_stall=1 throughout, IDLE on cycle 5.
REQ-035 mem_mem_write=1, mem_ready never high, MEM_TIMEOUT=15 -> return to IDLE after 15 wait cycles; mem_timeout=1 persists until reset.
REQ-036 branch_taken pulse in IDLE, FLUSH_CYCLES=2 -> if_id_flush=id_exe_flush=1 for 2 cycles, then IDLE.
REQ-037 branch_taken during MEM_WAIT -> FLUSH entered directly on mem_ready, 2 flush cycles, branch_pending cleared.
REQ-038 reset asserted between clock edges during MEM_WAIT -> ctrl_state=0 and all stalls=0 before the next edge.
